// File: rtl/imem_load_ctrl.sv
// Boot loader: packs a byte stream (N, then 4*N little-endian payload bytes) into imem words,
// then releases the core. Optional trailing XOR checksum byte when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_load_ctrl #(
   parameter int DEPTH_BYTES = 64,
   parameter int ADDR_W      = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_run,
   output logic              load_done,
   output logic              err
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int WCNT_W = $clog2(WORDS + 1);
   localparam logic [7:0] MAX_N = 8'(WORDS);
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

`ifdef IMEM_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHK, RUN} state_e;
`else
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN} state_e;
`endif

   state_e             state_q, state_d;
   logic [WCNT_W-1:0]  n_q, n_d;
   logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [3:0][7:0]    buf_q, buf_d;
   logic               rx_ready_q, rx_ready_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               core_run_q, core_run_d;
   logic               load_done_q, load_done_d;
   logic               err_q, err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [7:0]         csum_q, csum_d;
`endif

   logic accept, hdr_ok, last_word;

   assign accept    = rx_valid && rx_ready_q;
   assign hdr_ok    = (rx_data != 8'd0) && (rx_data <= MAX_N);
   assign last_word = ((word_cnt_q + WCNT_ONE) == n_q);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         n_q         <= '0;
         word_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         buf_q       <= '0;
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         core_run_q  <= 1'b0;
         load_done_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_cnt_q  <= word_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         buf_q       <= buf_d;
         rx_ready_q  <= rx_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_run_q  <= core_run_d;
         load_done_q <= load_done_d;
         err_q       <= err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && hdr_ok) state_d = LOAD;
         LOAD:    if (accept && (byte_cnt_q == 2'd3)) state_d = WRITE;
`ifdef IMEM_LOAD_CHECKSUM_EN
         WRITE:   state_d = last_word ? CHK : LOAD;
         CHK:     if (accept) state_d = (rx_data == csum_q) ? RUN : IDLE;
`else
         WRITE:   state_d = last_word ? RUN : LOAD;
`endif
         RUN:     if (load_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      rx_ready_d  = (state_d != WRITE) && (state_d != RUN);
      mem_we_d    = (state_d == WRITE);
      core_run_d  = (state_d == RUN);
      load_done_d = (state_d == RUN) && (state_q != RUN);
      n_d         = n_q;
      word_cnt_d  = word_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      buf_d       = buf_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (hdr_ok) begin
                  n_d   = WCNT_W'(rx_data);
                  err_d = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  csum_d = '0;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               buf_d[byte_cnt_q] = rx_data;
               byte_cnt_d        = byte_cnt_q + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
               csum_d            = csum_q ^ rx_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  mem_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
                  mem_wdata_d = buf_d;
               end
            end
         end
         WRITE: word_cnt_d = word_cnt_q + WCNT_ONE;
`ifdef IMEM_LOAD_CHECKSUM_EN
         CHK: if (accept && (rx_data != csum_q)) err_d = 1'b1;
`endif
         default: ;
      endcase
      // Any return to IDLE starts the next image from word 0, byte lane 0.
      if (state_d == IDLE) begin
         word_cnt_d = '0;
         byte_cnt_d = '0;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign core_run  = core_run_q;
   assign load_done = load_done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: directed spec scenarios plus randomized images with rx_valid gaps,
// checked against a byte-stream reference model of the expected imem writes.
module tb_imem_load_ctrl;

   logic        clock;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        load_req;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_run;
   logic        load_done;
   logic        err;

   int checks;
   int errors;
   int done_cnt;

   logic [7:0]  stream[$];
   logic [5:0]  exp_addr[$];
   logic [31:0] exp_data[$];
   logic [5:0]  mon_addr[$];
   logic [31:0] mon_data[$];

   imem_load_ctrl #(.DEPTH_BYTES(64), .ADDR_W(6)) dut (
      .clock     (clock),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .load_req  (load_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_run  (core_run),
      .load_done (load_done),
      .err       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record every imem write and every load_done cycle, sampled mid-cycle.
   always @(negedge clock) begin
      if (mem_we === 1'b1) begin
         mon_addr.push_back(mem_addr);
         mon_data.push_back(mem_wdata);
      end
      if (load_done === 1'b1) done_cnt++;
   end

   function automatic void push4(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
      stream.push_back(b0);
      stream.push_back(b1);
      stream.push_back(b2);
      stream.push_back(b3);
   endfunction

   function automatic void seal();
`ifdef IMEM_LOAD_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      for (int i = 1; i < stream.size(); i++) x ^= stream[i];
      stream.push_back(x);
`endif
   endfunction

   // Reference: word i lands at byte address 4*i, assembled little-endian from the payload.
   function automatic void model();
      int n;
      exp_addr.delete();
      exp_data.delete();
      n = int'(stream[0]);
      if (n >= 1 && n <= 16) begin
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(6'(4 * i));
            exp_data.push_back({stream[4*i+4], stream[4*i+3], stream[4*i+2], stream[4*i+1]});
         end
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clock);
         rx_data  = b;
         rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rx_valid && rx_ready) done = 1'b1;
         @(posedge clock);
         #1 rx_valid = 1'b0;
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL send_byte: byte %h not accepted, rx_ready=%b, required acceptance within 200 cycles", b, rx_ready);
      end
   endtask

   task automatic send_stream(input int from, input bit gaps);
      for (int i = from; i < stream.size(); i++) send_byte(stream[i], gaps);
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (core_run === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic request_reload();
      @(negedge clock);
      load_req = 1'b1;
      @(negedge clock);
      load_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      load_req = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({rx_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, err} !== 43'd0) begin
         errors++;
         $display("[TB] FAIL reset values: rdy=%b we=%b addr=%h wdata=%h run=%b done=%b err=%b, required all 0",
                  rx_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, err);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (rx_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready after release: rx_ready=%b, required 1", rx_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] words[3];
      bit ok;
      words[0] = 32'h002081b3;
      words[1] = 32'h404182b3;
      words[2] = 32'h0061c3b3;
      stream.delete();
      stream.push_back(8'h03);
      push4(8'hb3, 8'h81, 8'h20, 8'h00);
      push4(8'hb3, 8'h82, 8'h41, 8'h40);
      push4(8'hb3, 8'hc3, 8'h61, 8'h00);
      seal();
      send_byte(stream[0], 1'b0);
      for (int w = 0; w < 3; w++) begin
         for (int b = 0; b < 4; b++) send_byte(stream[1 + 4*w + b], 1'b0);
         @(negedge clock);
         checks++;
         if (mem_we !== 1'b1 || mem_addr !== 6'(4 * w) || mem_wdata !== words[w]) begin
            errors++;
            $display("[TB] FAIL basic write %0d: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                     w, mem_we, mem_addr, mem_wdata, 6'(4 * w), words[w]);
         end
      end
      send_stream(13, 1'b0);
      wait_run(ok);
      checks++;
      if (!ok || load_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic release: core_run=%b load_done=%b, required 1 and 1", core_run, load_done);
      end
      @(negedge clock);
      checks++;
      if (load_done !== 1'b0 || core_run !== 1'b1 || rx_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic run hold: load_done=%b core_run=%b rx_ready=%b, required 0 1 0",
                  load_done, core_run, rx_ready);
      end
   endtask

   task automatic test_reload();
      bit ok;
      request_reload();
      checks++;
      if (core_run !== 1'b0 || rx_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reload request: core_run=%b rx_ready=%b, required 0 1", core_run, rx_ready);
      end
      mon_addr.delete();
      mon_data.delete();
      stream.delete();
      stream.push_back(8'h01);
      push4(8'h13, 8'h00, 8'h00, 8'h00);
      seal();
      send_stream(0, 1'b0);
      wait_run(ok);
      checks++;
      if (!ok || mon_addr.size() != 1) begin
         errors++;
         $display("[TB] FAIL reload run: core_run=%b writes=%0d, required 1 and 1", core_run, mon_addr.size());
      end else begin
         checks++;
         if (mon_addr[0] !== 6'd0 || mon_data[0] !== 32'h00000013) begin
            errors++;
            $display("[TB] FAIL reload word: addr=%h data=%h, required 00 00000013", mon_addr[0], mon_data[0]);
         end
      end
   endtask

   task automatic test_bad_header();
      bit ok;
      request_reload();
      mon_addr.delete();
      mon_data.delete();
      send_byte(8'h00, 1'b0);
      @(negedge clock);
      checks++;
      if (err !== 1'b1 || rx_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL header 00: err=%b rx_ready=%b, required 1 1", err, rx_ready);
      end
      send_byte(8'h11, 1'b0);
      repeat (3) @(negedge clock);
      checks++;
      if (err !== 1'b1 || mon_addr.size() != 0 || core_run !== 1'b0 || rx_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL header 11: err=%b writes=%0d core_run=%b rx_ready=%b, required 1 0 0 1",
                  err, mon_addr.size(), core_run, rx_ready);
      end
      stream.delete();
      stream.push_back(8'h01);
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      seal();
      model();
      send_byte(stream[0], 1'b0);
      @(negedge clock);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL header 01 clears err: err=%b, required 0", err);
      end
      send_stream(1, 1'b0);
      wait_run(ok);
      checks++;
      if (!ok || mon_data.size() != 1 || mon_data[0] !== exp_data[0]) begin
         errors++;
         $display("[TB] FAIL header 01 load: core_run=%b writes=%0d, required 1 and 1 matching word", core_run, mon_data.size());
      end
   endtask

   task automatic test_gaps();
      bit ok;
      int d0;
      request_reload();
      mon_addr.delete();
      mon_data.delete();
      stream.delete();
      stream.push_back(8'h03);
      push4(8'hb3, 8'h81, 8'h20, 8'h00);
      push4(8'hb3, 8'h82, 8'h41, 8'h40);
      push4(8'hb3, 8'hc3, 8'h61, 8'h00);
      seal();
      model();
      d0 = done_cnt;
      send_stream(0, 1'b1);
      wait_run(ok);
      repeat (2) @(negedge clock);
      checks++;
      if (!ok || done_cnt - d0 != 1) begin
         errors++;
         $display("[TB] FAIL gaps release: core_run=%b load_done cycles=%0d, required 1 and 1", core_run, done_cnt - d0);
      end
      checks++;
      if (mon_addr.size() != exp_addr.size()) begin
         errors++;
         $display("[TB] FAIL gaps write count: got %0d, required %0d", mon_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < mon_addr.size() && i < exp_addr.size(); i++) begin
         checks++;
         if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
            errors++;
            $display("[TB] FAIL gaps write %0d: addr=%h data=%h, required addr=%h data=%h",
                     i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int n;
      bit gaps;
      for (int k = 0; k < 6; k++) begin
         request_reload();
         mon_addr.delete();
         mon_data.delete();
         n = (k == 0) ? 16 : $urandom_range(1, 16);
         gaps = 1'($urandom_range(0, 1));
         stream.delete();
         stream.push_back(8'(n));
         for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
         seal();
         model();
         send_stream(0, gaps);
         wait_run(ok);
         checks++;
         if (!ok || mon_addr.size() != exp_addr.size()) begin
            errors++;
            $display("[TB] FAIL random %0d: core_run=%b writes=%0d, required 1 and %0d",
                     k, core_run, mon_addr.size(), exp_addr.size());
         end
         for (int i = 0; i < mon_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
               errors++;
               $display("[TB] FAIL random %0d write %0d: addr=%h data=%h, required addr=%h data=%h",
                        k, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      request_reload();
      mon_addr.delete();
      mon_data.delete();
      stream.delete();
      stream.push_back(8'h02);
      for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
      model();
      for (int i = 0; i < 7; i++) send_byte(stream[i], 1'b0);
      repeat (3) @(negedge clock);
      checks++;
      if (mon_addr.size() != 1 || mon_addr[0] !== 6'd0 || mon_data[0] !== exp_data[0]) begin
         errors++;
         $display("[TB] FAIL partial load: writes=%0d, required exactly addr 00 data %h", mon_addr.size(), exp_data[0]);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({rx_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, err} !== 43'd0) begin
         errors++;
         $display("[TB] FAIL mid reset values: rdy=%b we=%b addr=%h wdata=%h run=%b done=%b err=%b, required all 0",
                  rx_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, err);
      end
      reset = 1'b1;
      mon_addr.delete();
      mon_data.delete();
      stream.delete();
      stream.push_back(8'h01);
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      seal();
      model();
      send_stream(0, 1'b0);
      wait_run(ok);
      checks++;
      if (!ok || mon_addr.size() != 1 || mon_addr[0] !== 6'd0 || mon_data[0] !== exp_data[0]) begin
         errors++;
         $display("[TB] FAIL load after reset: core_run=%b writes=%0d, required 1 and one word at 00", core_run, mon_addr.size());
      end
   endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
   task automatic test_checksum();
      bit ok;
      request_reload();
      stream.delete();
      stream.push_back(8'h01);
      push4(8'h33, 8'h03, 8'h94, 8'h00);
      stream.push_back(8'ha4);
      send_stream(0, 1'b0);
      wait_run(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL checksum good: core_run=%b, required 1", core_run);
      end
      request_reload();
      stream[5] = 8'ha5;
      send_stream(0, 1'b0);
      repeat (4) @(negedge clock);
      checks++;
      if (err !== 1'b1 || core_run !== 1'b0 || rx_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL checksum bad: err=%b core_run=%b rx_ready=%b, required 1 0 1", err, core_run, rx_ready);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      done_cnt = 0;
      test_reset();
      test_basic();
      test_reload();
      test_bad_header();
      test_gaps();
      test_random();
      test_reset_mid();
`ifdef IMEM_LOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
